// File: rtl/mult_bridge_pkg.sv
// Shared types and constants for the CPU-to-multiplier bus bridge.
package mult_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WSTB   = 3'd1,
        ST_WWAIT  = 3'd2,
        ST_RWAIT0 = 3'd3,
        ST_RSTB   = 3'd4,
        ST_RWAIT  = 3'd5,
        ST_RDONE  = 3'd6
    } state_t;

    localparam logic [1:0]  SEL_A        = 2'd0;
    localparam logic [1:0]  SEL_B        = 2'd1;
    localparam logic [1:0]  SEL_START    = 2'd2;
    localparam logic [1:0]  SEL_RESULT   = 2'd3;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // States in which the peripheral may stall us and the timeout guard runs.
    function automatic logic is_wait(input state_t s);
        return (s == ST_WWAIT) || (s == ST_RWAIT0) || (s == ST_RWAIT);
    endfunction

endpackage

// File: rtl/bridge_timeout.sv
// Wait-cycle counter: held at zero outside wait states, flags the last allowed cycle.
module bridge_timeout #(
    parameter int CNT_W   = 11,
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    // Fires in the TIMEOUT-th cycle spent waiting, so the FSM leaves on that edge.
    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/mult_bus_bridge.sv
// femtorv32 memory bus to multiplier peripheral bridge: decode, strobe generation,
// CPU stall and a timeout guard against a hung peripheral.
module mult_bus_bridge
    import mult_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          TIMEOUT   = 1024,
    parameter int          CNT_W     = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_wbusy,
    output logic        mem_rbusy,
    output logic [1:0]  p_sel,
    output logic [31:0] p_wdata,
    output logic        p_wstrb,
    output logic        p_rstrb,
    input  logic [31:0] p_rdata,
    input  logic        p_wbusy,
    input  logic        p_rbusy,
    output logic        err
);

    state_t      state;
    logic        rd_pend;
    logic [1:0]  rd_sel_q;
    logic [31:0] rdata_q;
    logic        expired;
    logic        hit, idle, in_wait, wr_acc, rd_hit, rd_go;
    logic [1:0]  sel_in, rd_sel;
    logic        unused_addr;

    assign unused_addr = ^mem_addr[1:0];

    assign hit     = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign sel_in  = mem_addr[3:2];
    assign idle    = (state == ST_IDLE);
    assign in_wait = is_wait(state);
    assign wr_acc  = idle && !rd_pend && hit && (mem_wmask == 4'hF);
    assign rd_hit  = idle && hit && mem_rstrb;
    // A read that arrived with a write is parked in rd_pend and wins the next IDLE.
    assign rd_go   = idle && !wr_acc && (rd_pend || (hit && mem_rstrb));
    assign rd_sel  = rd_pend ? rd_sel_q : sel_in;

    assign mem_wbusy = wr_acc || (state == ST_WSTB) || (state == ST_WWAIT);
    assign mem_rbusy = rd_hit || rd_pend || (state == ST_RWAIT0) ||
                       (state == ST_RSTB) || (state == ST_RWAIT);
    assign mem_rdata = (state == ST_RDONE) ? rdata_q : '0;

    bridge_timeout #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_wait),
        .en      (in_wait),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            rd_pend  <= 1'b0;
            rd_sel_q <= '0;
            rdata_q  <= '0;
            p_sel    <= '0;
            p_wdata  <= '0;
            p_wstrb  <= 1'b0;
            p_rstrb  <= 1'b0;
            err      <= 1'b0;
        end else begin
            p_wstrb <= 1'b0;
            p_rstrb <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (wr_acc) begin
                        p_sel    <= sel_in;
                        p_wdata  <= mem_wdata;
                        p_wstrb  <= 1'b1;
                        rd_pend  <= hit && mem_rstrb;
                        rd_sel_q <= sel_in;
                        state    <= ST_WSTB;
                    end else if (rd_go) begin
                        p_sel   <= rd_sel;
                        rd_pend <= 1'b0;
                        // RESULT is not readable while the multiplier is still running.
                        if (rd_sel == SEL_RESULT && p_wbusy) begin
                            state <= ST_RWAIT0;
                        end else begin
                            p_rstrb <= 1'b1;
                            state   <= ST_RSTB;
                        end
                    end
                end
                ST_WSTB:
                    state <= (p_sel == SEL_START) ? ST_WWAIT : ST_IDLE;
                ST_WWAIT: begin
                    if (!p_wbusy) begin
                        state <= ST_IDLE;
                    end else if (expired) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_RWAIT0: begin
                    if (!p_wbusy) begin
                        p_rstrb <= 1'b1;
                        state   <= ST_RSTB;
                    end else if (expired) begin
                        err     <= 1'b1;
                        rdata_q <= TIMEOUT_DATA;
                        state   <= ST_RDONE;
                    end
                end
                ST_RSTB:
                    state <= ST_RWAIT;
                ST_RWAIT: begin
                    if (!p_rbusy) begin
                        rdata_q <= p_rdata;
                        state   <= ST_RDONE;
                    end else if (expired) begin
                        err     <= 1'b1;
                        rdata_q <= TIMEOUT_DATA;
                        state   <= ST_RDONE;
                    end
                end
                ST_RDONE:
                    state <= ST_IDLE;
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_bus_bridge.sv
// Bench for mult_bus_bridge: behavioural multiplier peripheral, CPU access tasks, shadow registers.
module tb_mult_bus_bridge;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;
    logic        mem_rstrb = 1'b0;

    logic [31:0] mem_rdata, p_wdata, p_rdata;
    logic        mem_wbusy, mem_rbusy, p_wstrb, p_rstrb, p_wbusy, p_rbusy, err;
    logic [1:0]  p_sel;

    logic [31:0] mem_rdata_t, p_wdata_t;
    logic        mem_wbusy_t, mem_rbusy_t, p_wstrb_t, p_rstrb_t, err_t;
    logic [1:0]  p_sel_t;
    logic [31:0] p_rdata_t = 32'h1234_5678;
    logic        p_wbusy_t = 1'b0;
    logic        p_rbusy_t = 1'b0;

    int total = 0, bad = 0;
    logic use_t = 1'b0;

    always #5 clk = ~clk;

    mult_bus_bridge dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .mem_wbusy(mem_wbusy), .mem_rbusy(mem_rbusy), .p_sel(p_sel),
        .p_wdata(p_wdata), .p_wstrb(p_wstrb), .p_rstrb(p_rstrb), .p_rdata(p_rdata),
        .p_wbusy(p_wbusy), .p_rbusy(p_rbusy), .err(err)
    );

    mult_bus_bridge #(.TIMEOUT(16), .CNT_W(5)) dut_t (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata_t),
        .mem_wbusy(mem_wbusy_t), .mem_rbusy(mem_rbusy_t), .p_sel(p_sel_t),
        .p_wdata(p_wdata_t), .p_wstrb(p_wstrb_t), .p_rstrb(p_rstrb_t), .p_rdata(p_rdata_t),
        .p_wbusy(p_wbusy_t), .p_rbusy(p_rbusy_t), .err(err_t)
    );

    // Multiplier peripheral model for the main instance.
    logic [31:0] pa = '0, pb = '0, pres = '0;
    int busy_cnt = 0, rb_cnt = 0, busy_len = 4;

    always @(posedge clk) begin
        if (p_wstrb) begin
            case (p_sel)
                2'd0: pa <= p_wdata;
                2'd1: pb <= p_wdata;
                2'd2: begin pres <= pa * pb; busy_cnt <= busy_len; end
                default: ;
            endcase
        end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (p_rstrb) rb_cnt <= int'($urandom_range(0, 3));
        else if (rb_cnt > 0) rb_cnt <= rb_cnt - 1;
    end

    assign p_wbusy = (busy_cnt != 0);
    assign p_rbusy = (rb_cnt != 0);
    always_comb begin
        p_rdata = '0;
        case (p_sel)
            2'd0: p_rdata = pa;
            2'd1: p_rdata = pb;
            2'd3: p_rdata = pres;
            default: p_rdata = '0;
        endcase
    end

    // Strobe monitor.
    int cyc = 0, nw = 0, nr = 0, wcyc = 0, rcyc = 0, both_hi = 0, rs_busy = 0;
    int nw_t = 0, nr_t = 0, rs_busy_t = 0;
    logic [1:0]  wsel = '0, rsel = '0;
    logic [31:0] wdat = '0;

    always @(negedge clk) begin
        cyc++;
        if (p_wstrb) begin nw++; wsel = p_sel; wdat = p_wdata; wcyc = cyc; end
        if (p_rstrb) begin nr++; rsel = p_sel; rcyc = cyc; end
        if (p_wstrb && p_rstrb) both_hi++;
        if (p_rstrb && p_wbusy) rs_busy++;
        if (p_wstrb_t) nw_t++;
        if (p_rstrb_t) nr_t++;
        if (p_rstrb_t && p_wbusy_t) rs_busy_t++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic wb();
        return use_t ? mem_wbusy_t : mem_wbusy;
    endfunction
    function automatic logic rb();
        return use_t ? mem_rbusy_t : mem_rbusy;
    endfunction
    function automatic logic [31:0] rd_now();
        return use_t ? mem_rdata_t : mem_rdata;
    endfunction

    // One CPU access: request for one cycle, then wait for both stalls to drop.
    task automatic cpu_acc(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input logic rd,
                           output int wc, output int rc, output logic [31:0] d);
        logic w0, r0, done;
        @(posedge clk); #1;
        mem_addr = addr; mem_wdata = data; mem_wmask = mask; mem_rstrb = rd;
        @(negedge clk);
        w0 = wb(); r0 = rb();
        wc = int'(w0); rc = int'(r0); d = rd_now();
        @(posedge clk); #1;
        mem_addr = '0; mem_wdata = '0; mem_wmask = '0; mem_rstrb = 1'b0;
        if (w0 || r0) begin
            done = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (wb()) wc++;
                if (rb()) rc++;
                if (!wb() && !rb()) begin d = rd_now(); done = 1'b1; break; end
            end
            if (!done) begin
                total++; bad++;
                $display("FAIL cpu_acc_timeout addr=%h got busy stuck, want release", addr);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int n0, flag;
        mem_wmask = '0; mem_rstrb = 1'b0; use_t = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({mem_rdata, mem_wbusy, mem_rbusy, p_sel, p_wdata, p_wstrb, p_rstrb, err} !== '0) begin
            bad++; $display("FAIL reset_init got wb=%b rb=%b ws=%b rs=%b err=%b, want all 0",
                            mem_wbusy, mem_rbusy, p_wstrb, p_rstrb, err);
        end
        total++;
        if ({mem_rdata_t, mem_wbusy_t, mem_rbusy_t, p_sel_t, p_wdata_t, p_wstrb_t, p_rstrb_t, err_t} !== '0) begin
            bad++; $display("FAIL reset_init_t got nonzero outputs, want all 0");
        end
        @(posedge clk); #1 rst = 1'b1;
        busy_len = 50;
        @(posedge clk); #1;
        mem_addr = BASE + 8; mem_wdata = 32'd1; mem_wmask = 4'hF;
        @(posedge clk); #1;
        mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
        rst = 1'b0;
        n0 = nw;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if ({mem_rdata, mem_wbusy, mem_rbusy, p_sel, p_wdata, p_wstrb, p_rstrb, err} !== '0) begin
                bad++; $display("FAIL reset_mid cycle %0d got wb=%b ws=%b sel=%0d wd=%h, want all 0",
                                i, mem_wbusy, p_wstrb, p_sel, p_wdata);
            end
        end
        @(posedge clk); #1 rst = 1'b1;
        flag = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_wbusy || mem_rbusy || p_wstrb) flag++;
        end
        #1;
        total++;
        if (nw != n0 || flag != 0) begin
            bad++; $display("FAIL reset_no_strobe got strobes=%0d busy_cycles=%0d, want 0 0", nw - n0, flag);
        end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic op_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] esel, input string name);
        int wc, rc, n0;
        logic [31:0] d;
        n0 = nw;
        cpu_acc(addr, data, 4'hF, 1'b0, wc, rc, d);
        total++;
        if (wc != 2 || rc != 0) begin
            bad++; $display("FAIL %s_busy got wbusy=%0d rbusy=%0d, want 2 0", name, wc, rc);
        end
        total++;
        if (nw - n0 != 1 || wsel !== esel || wdat !== data) begin
            bad++; $display("FAIL %s_strobe got n=%0d sel=%0d wdata=%h, want 1 %0d %h",
                            name, nw - n0, wsel, wdat, esel, data);
        end
    endtask

    task automatic test_operands();
        op_write(BASE,     32'd7, 2'd0, "wr_a");
        op_write(BASE + 4, 32'd5, 2'd1, "wr_b");
    endtask

    task automatic start_and_read(input int blen, input logic [31:0] exp, input string name);
        int wc, rc, n0, r0, b0;
        logic [31:0] d;
        busy_len = blen;
        n0 = nw;
        cpu_acc(BASE + 8, 32'd1, 4'hF, 1'b0, wc, rc, d);
        total++;
        // accept + strobe cycles, blen busy cycles, one more cycle to see p_wbusy low
        if (wc != blen + 3 || p_wbusy !== 1'b0) begin
            bad++; $display("FAIL %s_start_busy got wbusy=%0d pbusy=%b, want %0d 0", name, wc, p_wbusy, blen + 3);
        end
        total++;
        if (nw - n0 != 1 || wsel !== 2'd2) begin
            bad++; $display("FAIL %s_start_strobe got n=%0d sel=%0d, want 1 2", name, nw - n0, wsel);
        end
        r0 = nr; b0 = rs_busy; n0 = nw;
        cpu_acc(BASE + 12, 32'd0, 4'h0, 1'b1, wc, rc, d);
        total++;
        if (d !== exp) begin bad++; $display("FAIL %s_rdata got %0d want %0d", name, d, exp); end
        total++;
        if (nr - r0 != 1 || rsel !== 2'd3 || nw != n0 || rs_busy != b0 || rc < 3) begin
            bad++; $display("FAIL %s_rstrobe got n=%0d sel=%0d wr=%0d early=%0d rbusy=%0d, want 1 3 0 0 >=3",
                            name, nr - r0, rsel, nw - n0, rs_busy - b0, rc);
        end
    endtask

    task automatic test_start_read();
        start_and_read(35, 32'd35, "start35");
    endtask

    task automatic test_busy_read();
        op_write(BASE,     32'd255, 2'd0, "wr_a255");
        op_write(BASE + 4, 32'd255, 2'd1, "wr_b255");
        start_and_read(100, 32'd65025, "mul255");
    endtask

    task automatic test_timeout();
        int wc, rc, n0, b0;
        logic [31:0] d;
        use_t = 1'b1; busy_len = 3; p_wbusy_t = 1'b1;
        total++;
        if (err_t !== 1'b0) begin bad++; $display("FAIL to_err_before got %b want 0", err_t); end
        n0 = nw_t;
        cpu_acc(BASE + 8, 32'd1, 4'hF, 1'b0, wc, rc, d);
        total++;
        if (wc != 18 || nw_t - n0 != 1) begin
            bad++; $display("FAIL to_write got wbusy=%0d strobes=%0d, want 18 1", wc, nw_t - n0);
        end
        total++;
        if (err_t !== 1'b1) begin bad++; $display("FAIL to_err_set got %b want 1", err_t); end
        n0 = nr_t; b0 = rs_busy_t;
        fork
            begin repeat (6) @(posedge clk); #1 p_wbusy_t = 1'b0; end
        join_none
        cpu_acc(BASE + 12, 32'd0, 4'h0, 1'b1, wc, rc, d);
        total++;
        if (d !== 32'h1234_5678 || nr_t - n0 != 1 || rs_busy_t != b0 || rc != 8) begin
            bad++; $display("FAIL to_rwait0 got d=%h n=%0d early=%0d rbusy=%0d, want 12345678 1 0 8",
                            d, nr_t - n0, rs_busy_t - b0, rc);
        end
        p_wbusy_t = 1'b1;
        n0 = nr_t;
        cpu_acc(BASE + 12, 32'd0, 4'h0, 1'b1, wc, rc, d);
        total++;
        if (d !== 32'hDEAD_BEEF || rc != 17 || nr_t != n0) begin
            bad++; $display("FAIL to_read got d=%h rbusy=%0d strobes=%0d, want deadbeef 17 0", d, rc, nr_t - n0);
        end
        p_wbusy_t = 1'b0;
        cpu_acc(BASE, 32'd0, 4'h0, 1'b1, wc, rc, d);
        total++;
        if (d !== 32'h1234_5678 || err_t !== 1'b1) begin
            bad++; $display("FAIL to_sticky got d=%h err=%b, want 12345678 1", d, err_t);
        end
        use_t = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    logic [31:0] shadow [2];

    task automatic test_decode();
        int wc, rc, n0, r0, wc0, rc0;
        logic [31:0] d;
        n0 = nw; r0 = nr;
        cpu_acc(BASE + 16, 32'd9, 4'hF, 1'b0, wc, rc, d);
        total++;
        if (wc != 0 || rc != 0 || nw != n0) begin
            bad++; $display("FAIL dec_miss_wr got wbusy=%0d strobes=%0d, want 0 0", wc, nw - n0);
        end
        cpu_acc(BASE, 32'd9, 4'h3, 1'b0, wc, rc, d);
        total++;
        if (wc != 0 || nw != n0) begin
            bad++; $display("FAIL dec_partial got wbusy=%0d strobes=%0d, want 0 0", wc, nw - n0);
        end
        cpu_acc(32'h0, 32'd0, 4'h0, 1'b1, wc, rc, d);
        total++;
        if (rc != 0 || d !== 32'd0 || nr != r0) begin
            bad++; $display("FAIL dec_miss_rd got rbusy=%0d d=%h strobes=%0d, want 0 0 0", rc, d, nr - r0);
        end
        wc0 = wcyc; rc0 = rcyc;
        cpu_acc(BASE, 32'h0000_ABCD, 4'hF, 1'b1, wc, rc, d);
        total++;
        if (nw - n0 != 1 || nr - r0 != 1 || !(wcyc > wc0 && rcyc > wcyc) || wc != 2) begin
            bad++; $display("FAIL dec_wr_rd_order got nw=%0d nr=%0d wcyc=%0d rcyc=%0d wbusy=%0d, want 1 1 w<r 2",
                            nw - n0, nr - r0, wcyc, rcyc, wc);
        end
        total++;
        if (d !== 32'h0000_ABCD) begin bad++; $display("FAIL dec_wr_rd_data got %h want 0000abcd", d); end
        shadow[0] = 32'h0000_ABCD;
        shadow[1] = 32'd255;
    endtask

    task automatic test_random();
        int wc, rc, n0, r0, k;
        logic [31:0] d, data, addr;
        logic [1:0] s;
        logic [3:0] m;
        for (int it = 0; it < 24; it++) begin
            k = int'($urandom_range(0, 3));
            s = 2'($urandom_range(0, 1));
            data = $urandom;
            n0 = nw; r0 = nr;
            case (k)
                0: begin
                    cpu_acc(BASE + 32'(s) * 4, data, 4'hF, 1'b0, wc, rc, d);
                    shadow[s] = data;
                    total++;
                    if (wc != 2 || nw - n0 != 1 || wdat !== data || wsel !== s) begin
                        bad++; $display("FAIL rnd_wr it=%0d got wbusy=%0d n=%0d wd=%h sel=%0d, want 2 1 %h %0d",
                                        it, wc, nw - n0, wdat, wsel, data, s);
                    end
                end
                1: begin
                    m = 4'($urandom_range(1, 14));
                    cpu_acc(BASE + 32'(s) * 4, data, m, 1'b0, wc, rc, d);
                    total++;
                    if (wc != 0 || nw != n0) begin
                        bad++; $display("FAIL rnd_partial it=%0d mask=%h got wbusy=%0d n=%0d, want 0 0",
                                        it, m, wc, nw - n0);
                    end
                end
                2: begin
                    cpu_acc(BASE + 32'(s) * 4, 32'd0, 4'h0, 1'b1, wc, rc, d);
                    total++;
                    if (d !== shadow[s] || nr - r0 != 1 || rc < 3) begin
                        bad++; $display("FAIL rnd_rd it=%0d sel=%0d got d=%h n=%0d rbusy=%0d, want %h 1 >=3",
                                        it, s, d, nr - r0, rc, shadow[s]);
                    end
                end
                default: begin
                    addr = BASE ^ (32'h10 << $urandom_range(0, 27));
                    cpu_acc(addr, data, s[0] ? 4'hF : 4'h0, !s[0], wc, rc, d);
                    total++;
                    if (wc != 0 || rc != 0 || d !== 32'd0 || nw != n0 || nr != r0) begin
                        bad++; $display("FAIL rnd_miss it=%0d addr=%h got wb=%0d rb=%0d d=%h, want 0 0 0",
                                        it, addr, wc, rc, d);
                    end
                end
            endcase
        end
        total++;
        if (both_hi != 0 || err !== 1'b0) begin
            bad++; $display("FAIL strobe_overlap got both=%0d err=%b, want 0 0", both_hi, err);
        end
    endtask

    initial begin
        test_reset();
        test_operands();
        test_start_read();
        test_busy_read();
        test_timeout();
        test_decode();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
